// File: rtl/nibble_serial_adder.sv
// Serial wide adder: streams WIDTH-bit operands through one 4-bit CLA,
// one nibble per clock, LSB nibble first, carry chained in a register.
//
// cla ports:
//   a, b   4-bit addends       cin   carry in
//   s      4-bit sum           cout  carry out of bit 3
//
// nibble_serial_adder ports:
//   clk, rst              clock, async active-high reset
//   in_valid, in_ready    operand handshake (a, b, cin)
//   a, b, cin             operands, sampled only on accept
//   out_valid, out_ready  result handshake
//   sum, cout             registered (a+b+cin), held until the next result

module cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0])
             | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        s    = p ^ c[3:0];
        cout = c[4];
    end
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4, >= 4");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [3:0]       nib_s;
    logic             nib_c;

    cla u_cla (
        .a    (opa[3:0]),
        .b    (opb[3:0]),
        .cin  (carry),
        .s    (nib_s),
        .cout (nib_c)
    );

    // New nibble enters at the top; after NIBBLES passes the
    // first nibble has reached bit 0.
    assign res_next = WIDTH'({nib_s, res} >> 4);

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    opa   <= opa >> 4;
                    opb   <= opb >> 4;
                    res   <= res_next;
                    carry <= nib_c;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum   <= res_next;
                        cout  <= nib_c;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at WIDTH 16, 4 and 32.
// Stimulus pushes expected results; monitors pop on each handshake.

module tb_nibble_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    logic        iv16, ir16, c16, ov16, or16, co16;
    logic [15:0] a16, b16, s16;
    logic        iv4, ir4, c4, ov4, or4, co4;
    logic [3:0]  a4, b4, s4;
    logic        iv32, ir32, c32, ov32, or32, co32;
    logic [31:0] a32, b32, s32;

    logic [16:0] q16[$];
    logic [4:0]  q4[$];
    logic [32:0] q32[$];
    logic [16:0] e16;
    logic [4:0]  e4;
    logic [32:0] e32;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .cin(c16),
        .out_valid(ov16), .out_ready(or16),
        .sum(s16), .cout(co16)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .cin(c4),
        .out_valid(ov4), .out_ready(or4),
        .sum(s4), .cout(co4)
    );

    nibble_serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .cin(c32),
        .out_valid(ov32), .out_ready(or32),
        .sum(s32), .cout(co32)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ov16 && or16) begin
            if (q16.size() == 0) begin
                chk("res16_unexpected", {co16, s16}, 64'hDEAD);
            end else begin
                e16 = q16.pop_front();
                chk("res16", {co16, s16}, e16);
            end
        end
        if (!rst && ov4 && or4) begin
            if (q4.size() == 0) begin
                chk("res4_unexpected", {co4, s4}, 64'hDEAD);
            end else begin
                e4 = q4.pop_front();
                chk("res4", {co4, s4}, e4);
            end
        end
        if (!rst && ov32 && or32) begin
            if (q32.size() == 0) begin
                chk("res32_unexpected", {co32, s32}, 64'hDEAD);
            end else begin
                e32 = q32.pop_front();
                chk("res32", {co32, s32}, e32);
            end
        end
    end

    // Tasks are entered and left just after a rising edge.
    task automatic send16(input logic [15:0] x, input logic [15:0] y,
                          input logic c);
        int n = 0;
        while (!ir16 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("send16_ready", ir16, 1);
        a16 = x; b16 = y; c16 = c; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
    endtask

    task automatic done16();
        int n = 0;
        while (!ov16 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("done16_valid", ov16, 1);
        if (or16) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send4(input logic [3:0] x, input logic [3:0] y,
                         input logic c);
        int n = 0;
        while (!ir4 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("send4_ready", ir4, 1);
        a4 = x; b4 = y; c4 = c; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
    endtask

    task automatic send32(input logic [31:0] x, input logic [31:0] y,
                          input logic c);
        int n = 0;
        while (!ir32 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("send32_ready", ir32, 1);
        a32 = x; b32 = y; c32 = c; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
    endtask

    task automatic done32();
        int n = 0;
        while (!ov32 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("done32_valid", ov32, 1);
        @(posedge clk); #1;
    endtask

    logic [15:0] ca[3];
    logic [15:0] cb[3];
    logic        cc[3];
    int          acc[$];

    initial begin
        iv16 = 0; a16 = 0; b16 = 0; c16 = 0; or16 = 1;
        iv4  = 0; a4  = 0; b4  = 0; c4  = 0; or4  = 1;
        iv32 = 0; a32 = 0; b32 = 0; c32 = 0; or32 = 1;
        ca = '{16'hFFFF, 16'hFFFF, 16'h8000};
        cb = '{16'h0001, 16'h0000, 16'h8000};
        cc = '{1'b0, 1'b1, 1'b0};

        // reset state
        @(negedge clk);
        chk("rst_in_ready", ir16, 0);
        chk("rst_out_valid", ov16, 0);
        chk("rst_sum", s16, 0);
        chk("rst_cout", co16, 0);
        chk("rst_in_ready4", ir4, 0);
        @(posedge clk); #1;
        rst = 0;
        #1;
        chk("rel_in_ready", ir16, 1);

        // basic op with latency profile
        q16.push_back({1'b0, 16'h5555});
        send16(16'h1234, 16'h4321, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            chk("lat_out_valid", ov16, (i == 4));
            chk("busy_in_ready", ir16, 0);
        end
        @(posedge clk); #1;
        chk("pulse_out_valid", ov16, 0);
        chk("back_in_ready", ir16, 1);

        // carry ripple across every nibble
        for (int i = 0; i < 3; i++) begin
            q16.push_back({1'b1, 16'h0000});
            send16(ca[i], cb[i], cc[i]);
            done16();
        end

        // backpressure in DONE
        or16 = 0;
        q16.push_back({1'b0, 16'h0100});
        send16(16'h00FF, 16'h0001, 1'b0);
        done16();
        for (int i = 0; i < 3; i++) begin
            chk("bp_out_valid", ov16, 1);
            chk("bp_in_ready", ir16, 0);
            chk("bp_hold", {co16, s16}, {1'b0, 16'h0100});
            iv16 = (i == 1);
            a16 = 16'h1111; b16 = 16'h1111;
            @(posedge clk); #1;
        end
        iv16 = 0;
        or16 = 1;
        @(posedge clk); #1;
        chk("bp_release_ov", ov16, 0);
        chk("bp_release_ir", ir16, 1);

        // reset mid-operation
        send16(16'hAAAA, 16'h5555, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk("abort_out_valid", ov16, 0);
        chk("abort_sum", s16, 0);
        chk("abort_cout", co16, 0);
        chk("abort_in_ready", ir16, 0);
        @(posedge clk); #1;
        rst = 0;
        #1;
        chk("abort_rel_ir", ir16, 1);
        repeat (10) @(posedge clk);
        #1;

        // back-to-back with in_valid held
        q16.push_back({1'b0, 16'h5555});
        q16.push_back({1'b1, 16'h0000});
        a16 = 16'h1234; b16 = 16'h4321; c16 = 0; iv16 = 1;
        for (int n = 0; n < 40 && acc.size() < 2; n++) begin
            @(negedge clk);
            if (ir16) begin
                acc.push_back(cyc);
                @(posedge clk); #1;
                a16 = 16'hFFFF; b16 = 16'h0001;
            end
        end
        iv16 = 0;
        chk("b2b_accepts", acc.size(), 2);
        if (acc.size() == 2) chk("b2b_spacing", acc[1] - acc[0], 6);
        repeat (12) @(posedge clk);
        #1;

        // WIDTH=4
        q4.push_back({1'b1, 4'h2});
        send4(4'h9, 4'h8, 1'b1);
        chk("w4_not_yet", ov4, 0);
        @(posedge clk); #1;
        chk("w4_out_valid", ov4, 1);
        @(posedge clk); #1;

        // WIDTH=32 random against reference sum
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] x, y;
            logic c;
            x = $urandom;
            y = $urandom;
            c = 1'($urandom_range(0, 1));
            q32.push_back({1'b0, x} + {1'b0, y} + {32'd0, c});
            send32(x, y, c);
            done32();
        end

        repeat (5) @(posedge clk);
        #1;
        chk("q16_drained", q16.size(), 0);
        chk("q4_drained", q4.size(), 0);
        chk("q32_drained", q32.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
